// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous display update,
// per-slot blanking against ghosting, and optional leading-zero blanking.
module seg7_scan #(
    parameter int unsigned SCAN_DIV  = 32'd50_000,
    parameter int unsigned BLANK_CYC = 32'd1_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] VALS,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    input  logic        LZB,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DPO,
    output logic        FRAME
);

    localparam logic BLANK_NZ = (BLANK_CYC != 0);

    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [1:0]  idx;
    logic        in_blank;
    logic        in_blank_next;
    logic [15:0] pend_vals;
    logic [3:0]  pend_dp;
    logic [15:0] disp_vals;
    logic [3:0]  disp_dp;
    logic        frame_flag;
    logic        wrap;
    logic        boundary;
    logic [3:0]  digit;
    logic [3:0]  zero;
    logic        lz;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;
    logic        dpo_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // in_blank tracks cnt < BLANK_CYC incrementally so a zero blank time needs no special case
    always_comb begin
        wrap          = (cnt == SCAN_DIV - 1);
        boundary      = wrap && (idx == 2'd3);
        cnt_next      = wrap ? '0 : cnt + 32'd1;
        in_blank_next = (cnt_next == '0) ? BLANK_NZ : (in_blank && (cnt_next != BLANK_CYC));
        digit         = disp_vals[{idx, 2'b00} +: 4];
        for (int i = 0; i < 4; i++) begin
            zero[i] = (disp_vals[i*4 +: 4] == 4'd0);
        end
        case (idx)
            2'd3:    lz = zero[3];
            2'd2:    lz = zero[3] & zero[2];
            2'd1:    lz = zero[3] & zero[2] & zero[1];
            default: lz = 1'b0;
        endcase
        an_next  = 4'hF;
        seg_next = 7'h7F;
        dpo_next = 1'b1;
        if (!in_blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = (LZB && lz) ? 7'h7F : decode(digit);
            dpo_next = ~disp_dp[idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= '0;
            in_blank   <= BLANK_NZ;
            pend_vals  <= '0;
            pend_dp    <= '0;
            disp_vals  <= '0;
            disp_dp    <= '0;
            frame_flag <= 1'b0;
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DPO        <= 1'b1;
            FRAME      <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            in_blank <= in_blank_next;
            if (wrap) begin
                idx <= idx + 2'd1;
            end
            if (LOAD) begin
                pend_vals <= VALS;
                pend_dp   <= DP;
            end
            // A load on the boundary edge itself bypasses PEND into the next frame
            if (boundary) begin
                disp_vals <= LOAD ? VALS : pend_vals;
                disp_dp   <= LOAD ? DP : pend_dp;
            end
            frame_flag <= boundary;
            FRAME      <= frame_flag;
            AN         <= an_next;
            SEG        <= seg_next;
            DPO        <= dpo_next;
        end
    end

endmodule
